ch_serializer: RTL and testbench
================================

// Module: ch_serializer
//
// PURPOSE
// - Transmit-side companion to the valid/ready nibble queue: accepts one wide word per
//   handshake and emits it as BEATS narrow beats on a valid/ready stream that drives a
//   queue's enq port (io_enq_valid/io_enq_data/io_enq_ready).
// - Holds output stable under backpressure and marks the final beat of each word.
// - Supports back-to-back words with no idle bubble between them.
//
// PARAMETERS
// - DATA_W     4   width of one output beat
// - BEATS      4   beats per input word (>=2); input width = DATA_W*BEATS
// - LSB_FIRST  1   1: least-significant beat sent first; 0: most-significant first
//
// PORTS
// - clk            in   1              sole clock, rising edge
// - reset          in   1              asynchronous, active-high
// - io_in_valid    in   1              input word valid
// - io_in_data     in   DATA_W*BEATS   input word
// - io_in_ready    out  1              block can accept a word this cycle
// - io_out_valid   out  1              beat valid (connects to queue io_enq_valid)
// - io_out_data    out  DATA_W         beat data (connects to queue io_enq_data)
// - io_out_last    out  1              current beat is final beat of its word
// - io_out_ready   in   1              sink accepts beat (from queue io_enq_ready)
// - io_out_parity  out  1              only with CH_SERIALIZER_PARITY_EN
//
// BEHAVIOUR
// - Registers: state {IDLE,SEND}, shift[DATA_W*BEATS], cnt[clog2(BEATS)].
// - Reset (async): state=IDLE, cnt=0, shift=0; io_out_valid=0, io_out_last=0,
//   io_out_data=0, io_in_ready=1. Reset mid-word discards the remaining beats.
// - in_fire = io_in_valid & io_in_ready; out_fire = io_out_valid & io_out_ready.
// - io_out_valid = (state==SEND); io_out_last = (state==SEND) & (cnt==BEATS-1).
// - io_out_data = shift[DATA_W-1:0] if LSB_FIRST else shift[top DATA_W bits].
// - io_in_ready = (state==IDLE) | (io_out_last & io_out_ready) (comb path ready->ready).
// - IDLE: on in_fire load shift<=io_in_data, cnt<=0, go SEND (first beat valid next cycle;
//   latency in_fire -> first beat = 1 cycle).
// - SEND, out_fire, cnt<BEATS-1: shift by DATA_W toward output end, cnt<=cnt+1.
// - SEND, out_fire, last beat: if io_in_valid load new word, cnt<=0, stay SEND
//   (no bubble); else go IDLE.
// - SEND, !io_out_ready: shift/cnt/outputs held; data must not change while valid.
// - io_in_data ignored except on in_fire; io_in_valid ignored in SEND before last beat.
// - cnt never exceeds BEATS-1; no wrap path other than reload/IDLE.
//
// CONFIGURATION
// - CH_SERIALIZER_PARITY_EN defined: port io_out_parity present, = XOR of io_out_data
//   (even parity, comb from the held beat); 0 when io_out_valid=0 and in reset.
// - Not defined: port absent; all other behaviour identical.
//
// TESTING (defaults: DATA_W=4, BEATS=4, LSB_FIRST=1)
// - Reset: assert reset async mid-cycle -> io_out_valid=0, io_in_ready=1 immediately.
// - Single word 0xA5C3, out_ready=1 -> beats 3,C,5,A on 4 consecutive cycles,
//   io_out_last=1 only on A, then IDLE.
// - Back-to-back 0x1234 then 0xBEEF, both valid -> 8 consecutive beats 4,3,2,1,F,E,E,B,
//   no bubble; io_in_ready=1 exactly on the cycle beat 1 fires.
// - Backpressure: out_ready low 3 cycles on beat 2 of 0x1234 -> data=3 held stable,
//   cnt unchanged, sequence resumes; in_ready stays 0.
// - Drive ch_queue enq (depth 2) with slow deq -> no beat lost/duplicated, order kept.
// - Reset during beat 2 -> remaining beats dropped; next word 0x0F0F sent cleanly
//   (F,0,F,0); with PARITY_EN parity = 0 on each beat.

Source files
------------

// File: rtl/ch_serializer.sv
// Wide-word to narrow-beat serializer: 1-cycle latency from input handshake to first beat, and no bubble between words.
// Output beat is held stable while io_out_ready is low. Optional io_out_parity port is enabled by defining CH_SERIALIZER_PARITY_EN.
module ch_serializer #(
  parameter int DATA_W    = 4,
  parameter int BEATS     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_in_valid,
  input  logic [DATA_W*BEATS-1:0]  io_in_data,
  output logic                     io_in_ready,
  output logic                     io_out_valid,
  output logic [DATA_W-1:0]        io_out_data,
  output logic                     io_out_last,
  input  logic                     io_out_ready
`ifdef CH_SERIALIZER_PARITY_EN
  ,
  output logic                     io_out_parity
`endif
);

  localparam int W     = DATA_W * BEATS;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_shift;
  logic [W-1:0]     w_shift_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [W-1:0]     w_shift_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Shift toward whichever end io_out_data is taken from.
  always_comb begin
    if (LSB_FIRST != 0) w_shift_adv = r_shift >> DATA_W;
    else                w_shift_adv = r_shift << DATA_W;
  end

  always_comb begin
    w_in_fire   = io_in_valid && io_in_ready;
    w_out_fire  = io_out_valid && io_out_ready;
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_in_fire) begin
          w_shift_nxt = io_in_data;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_out_fire) begin
          if (r_cnt != LAST_CNT) begin
            w_shift_nxt = w_shift_adv;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end else if (w_in_fire) begin
            w_shift_nxt = io_in_data;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // io_in_ready depends combinationally on io_out_ready so a new word can load on the last beat.
  always_comb begin
    io_out_valid = (r_state == ST_SEND);
    io_out_last  = (r_state == ST_SEND) && (r_cnt == LAST_CNT);
    io_in_ready  = (r_state == ST_IDLE) || (io_out_last && io_out_ready);
    if (LSB_FIRST != 0) io_out_data = r_shift[DATA_W-1:0];
    else                io_out_data = r_shift[W-1 -: DATA_W];
`ifdef CH_SERIALIZER_PARITY_EN
    io_out_parity = io_out_valid ? ^io_out_data : 1'b0;
`endif
  end

endmodule

// File: tb/tb_ch_serializer.sv
// Bench for ch_serializer: directed and random stimulus checked against a word/beat-index reference model.
module tb_ch_serializer;

  localparam int DATA_W    = 4;
  localparam int BEATS     = 4;
  localparam int LSB_FIRST = 1;
  localparam int W         = DATA_W * BEATS;

  logic              clk = 1'b0;
  logic              reset;
  logic              io_in_valid;
  logic [W-1:0]      io_in_data;
  logic              io_in_ready;
  logic              io_out_valid;
  logic [DATA_W-1:0] io_out_data;
  logic              io_out_last;
  logic              io_out_ready;
`ifdef CH_SERIALIZER_PARITY_EN
  logic              io_out_parity;
`endif

  ch_serializer #(.DATA_W(DATA_W), .BEATS(BEATS), .LSB_FIRST(LSB_FIRST)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_data   (io_in_data),
    .io_in_ready  (io_in_ready),
    .io_out_valid (io_out_valid),
    .io_out_data  (io_out_data),
    .io_out_last  (io_out_last),
    .io_out_ready (io_out_ready)
`ifdef CH_SERIALIZER_PARITY_EN
    ,
    .io_out_parity(io_out_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the word in flight and which beat of it is presented.
  bit                m_act;
  logic [W-1:0]      m_word;
  int                m_idx;
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] beat_of(input logic [W-1:0] word, input int idx);
    if (LSB_FIRST != 0) return DATA_W'(word >> (idx * DATA_W));
    else                return DATA_W'(word >> ((BEATS - 1 - idx) * DATA_W));
  endfunction

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input string tag,
                       output bit acc);
    logic e_last, e_rdy, out_f;
    @(negedge clk);
    io_in_valid  = v;
    io_in_data   = d;
    io_out_ready = r;
    #1;
    e_last = m_act && (m_idx == BEATS - 1);
    e_rdy  = !m_act || (e_last && r);
    chk({tag, ".valid"}, io_out_valid, m_act);
    chk({tag, ".last"}, io_out_last, e_last);
    chk({tag, ".in_ready"}, io_in_ready, e_rdy);
    if (m_act) chk({tag, ".data"}, io_out_data, beat_of(m_word, m_idx));
`ifdef CH_SERIALIZER_PARITY_EN
    chk({tag, ".parity"}, io_out_parity, m_act ? ^beat_of(m_word, m_idx) : 1'b0);
`endif
    acc   = v && e_rdy;
    out_f = m_act && r;
    if (out_f) got_q.push_back(io_out_data);
    @(posedge clk);
    if (out_f) begin
      if (e_last) m_act = 1'b0;
      else        m_idx++;
    end
    if (acc) begin
      m_act  = 1'b1;
      m_word = d;
      m_idx  = 0;
    end
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset       = 1'b1;
    io_in_valid = 1'b0;
    #1;
    chk({tag, ".rst_valid"}, io_out_valid, 1'b0);
    chk({tag, ".rst_in_ready"}, io_in_ready, 1'b1);
    chk({tag, ".rst_last"}, io_out_last, 1'b0);
    chk({tag, ".rst_data"}, io_out_data, '0);
`ifdef CH_SERIALIZER_PARITY_EN
    chk({tag, ".rst_parity"}, io_out_parity, 1'b0);
`endif
    m_act = 1'b0;
    m_idx = 0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic chk_seq(input string tag, input logic [DATA_W-1:0] e[8], input int n);
    chk({tag, ".count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk({tag, ".beat"}, got_q[i], e[i]);
    got_q.delete();
  endtask

  initial begin
    bit acc;
    int wi;
    logic [W-1:0] words[3];
    logic [DATA_W-1:0] e[8];

    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_data   = '0;
    io_out_ready = 1'b0;
    m_act        = 1'b0;
    m_word       = '0;
    m_idx        = 0;
    #1;
    chk("init.valid", io_out_valid, 1'b0);
    chk("init.in_ready", io_in_ready, 1'b1);
    chk("init.data", io_out_data, '0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    // Single word
    cycle(1'b1, 16'hA5C3, 1'b1, "single", acc);
    repeat (6) cycle(1'b0, 16'h0, 1'b1, "single", acc);
    e = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0};
    chk_seq("single", e, 4);

    // Back-to-back words, valid held through the first word
    cycle(1'b1, 16'h1234, 1'b1, "b2b", acc);
    repeat (4) cycle(1'b1, 16'hBEEF, 1'b1, "b2b", acc);
    repeat (5) cycle(1'b0, 16'h0, 1'b1, "b2b", acc);
    e = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hF, 4'hE, 4'hE, 4'hB};
    chk_seq("b2b", e, 8);

    // Backpressure on the second beat
    cycle(1'b1, 16'h1234, 1'b1, "bp", acc);
    cycle(1'b0, 16'h0, 1'b1, "bp", acc);
    repeat (3) cycle(1'b1, 16'h5555, 1'b0, "bp", acc);
    repeat (5) cycle(1'b0, 16'h0, 1'b1, "bp", acc);
    e = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    chk_seq("bp", e, 4);

    // Reset in the middle of a word, then a clean word
    cycle(1'b1, 16'h1234, 1'b1, "midrst", acc);
    cycle(1'b0, 16'h0, 1'b1, "midrst", acc);
    async_reset("midrst");
    cycle(1'b1, 16'h0F0F, 1'b1, "after_rst", acc);
    repeat (5) cycle(1'b0, 16'h0, 1'b1, "after_rst", acc);
    e = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    chk_seq("after_rst", e, 4);

    // Depth-2 sink with slow drain
    words = '{16'h1357, 16'h2468, 16'h9ABC};
    wi = 0;
    exp_q.delete();
    for (int c = 0; c < 90; c++) begin
      cycle(wi < 3, words[(wi < 3) ? wi : 0], got_q.size() < 2, "sink", acc);
      if (acc) begin
        for (int b = 0; b < BEATS; b++) exp_q.push_back(beat_of(words[wi], b));
        wi++;
      end
      if ((c % 3 == 2) && got_q.size() > 0) begin
        if (exp_q.size() > 0) chk("sink.order", got_q.pop_front(), exp_q.pop_front());
        else                  chk("sink.extra_beat", got_q.pop_front(), 'x);
      end
    end
    chk("sink.words", wi, 3);
    chk("sink.drained", exp_q.size() + got_q.size(), 0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0, "rand", acc);
      got_q.delete();
      if (c == 300) async_reset("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
